// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader: frame/receiver state
// enumerations, the sync byte, the oversample ratio and a debug snapshot struct.
package loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK, S_RUN, S_FAIL
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_e;

  typedef struct packed {
    loader_state_e frame;
    rx_state_e     rx;
  } loader_dbg_t;

  localparam logic [7:0] SYNC_BYTE  = 8'h55;
  localparam int         OVERSAMPLE = 16;

  function automatic logic is_busy(input loader_state_e s);
    return (s inside {S_LEN_H, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA, S_CHK});
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling: two-flop synchronizer, tick divider
// and bit FSM. Emits a one-cycle valid strobe or a frame_err strobe per byte.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o,
  output rx_state_e  dbg_state_o
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             sync1_q, sync2_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       smp_q, smp_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             tick;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = (div_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        div_d = '0;
        smp_d = '0;
        bit_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (tick) begin
          if (smp_q == 4'd7) begin
            smp_d   = '0;
            state_d = sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            smp_d = smp_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'd15) begin
            shift_d = {sync2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          smp_d = smp_q + 4'd1;
          if (smp_q == 4'd15) begin
            state_d = RX_IDLE;
            if (sync2_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      div_q   <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign dbg_state_o = state_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Frame FSM that loads a UART-delivered image into memory, verifies its
// checksum and holds the CPU in reset until a good image (or bypass) arrives.
module uart_boot_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        UART_RX,
  input  logic        BYPASS,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA,
  output logic        CPU_RESET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output loader_dbg_t DBG
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [7:0]    rx_data;
  logic          rx_valid, rx_ferr;
  rx_state_e     rx_state;

  // Handshake: rx_valid is a one-cycle strobe with no ready; every strobe is
  // consumed in the cycle it appears, so back-to-back bytes never stall.
  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .rx_i        (UART_RX),
    .data_o      (rx_data),
    .valid_o     (rx_valid),
    .frame_err_o (rx_ferr),
    .dbg_state_o (rx_state)
  );

  loader_state_e state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic [15:0]   maddr_q, maddr_d;
  logic [7:0]    mdata_q, mdata_d;
  logic          busy, is_sync;

  assign busy    = is_busy(state_q);
  assign is_sync = rx_valid && (rx_data == SYNC_BYTE);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    tmo_d   = '0;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    if (busy) tmo_d = rx_valid ? '0 : tmo_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (is_sync)                 state_d = S_LEN_H;
        else if (!rx_valid && BYPASS) state_d = S_RUN;
      end
      S_LEN_H: if (rx_valid) begin
        len_d   = {rx_data, len_q[7:0]};
        state_d = S_LEN_L;
      end
      S_LEN_L: if (rx_valid) begin
        len_d   = {len_q[15:8], rx_data};
        state_d = S_ADDR_H;
      end
      S_ADDR_H: if (rx_valid) begin
        addr_d  = {rx_data, addr_q[7:0]};
        state_d = S_ADDR_L;
      end
      S_ADDR_L: if (rx_valid) begin
        addr_d  = {addr_q[15:8], rx_data};
        state_d = (len_q != 16'd0) ? S_DATA : S_CHK;
      end
      S_DATA: if (rx_valid) begin
        we_d    = 1'b1;
        maddr_d = addr_q;
        mdata_d = rx_data;
        addr_d  = addr_q + 16'd1;
        sum_d   = sum_q + rx_data;
        len_d   = len_q - 16'd1;
        if (len_q == 16'd1) state_d = S_CHK;
      end
      S_CHK: if (rx_valid) begin
        state_d = (rx_data == sum_q) ? S_RUN : S_FAIL;
      end
      S_RUN, S_FAIL: if (is_sync) state_d = S_LEN_H;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_LEN_H && state_q != S_LEN_H) begin
      sum_d = '0;
      len_d = '0;
    end
    // A bad stop bit or an inter-byte stall aborts any frame in progress.
    if (busy && (rx_ferr || (!rx_valid && tmo_q == TW'(TIMEOUT_CYC - 1))))
      state_d = S_FAIL;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign MEM_WE    = we_q;
  assign MEM_ADDR  = maddr_q;
  assign MEM_DATA  = mdata_q;
  assign CPU_RESET = (state_q != S_RUN);
  assign BUSY      = busy;
  assign DONE      = (state_q == S_RUN);
  assign ERROR     = (state_q == S_FAIL);
  assign DBG       = '{frame: state_q, rx: rx_state};

endmodule
